// File: rtl/logicnet_layer_sched.sv
// Time-multiplexed LogicNets layer: N_NEURON LUT neurons evaluated one per cycle
// through one shared LUT RAM. Optional perf counters are enabled by LAYER_PERF_EN.
module logicnet_layer_sched #(
  parameter int unsigned IN_W     = 64,
  parameter int unsigned N_NEURON = 16,
  parameter int unsigned FANIN_W  = 7,
  parameter int unsigned OUT_BITS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [IN_W-1:0]              s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [N_NEURON*OUT_BITS-1:0] m_data,
  input  logic                         cfg_we,
  input  logic                         cfg_sel,
  input  logic [15:0]                  cfg_addr,
  input  logic [7:0]                   cfg_data,
  output logic                         cfg_err,
  output logic                         busy
`ifdef LAYER_PERF_EN
  ,
  output logic [31:0]                  perf_passes,
  output logic [31:0]                  perf_stall
`endif
);

  localparam int unsigned LUT_DEPTH  = N_NEURON * (32'd1 << FANIN_W);
  localparam int unsigned LA         = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
  localparam int unsigned CONN_DEPTH = N_NEURON * FANIN_W;
  localparam int unsigned CA         = (CONN_DEPTH > 1) ? $clog2(CONN_DEPTH) : 1;
  localparam int unsigned NW         = $clog2(N_NEURON + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_OUT
  } state_t;

  state_t                         r_state;
  state_t                         w_next;

  logic [IN_W-1:0]                r_vec;
  logic [NW-1:0]                  r_n;
  logic                           r_v1;
  logic [NW-1:0]                  r_n1;
  logic [LA-1:0]                  r_addr;
  logic                           r_v2;
  logic [NW-1:0]                  r_n2;
  logic [OUT_BITS-1:0]            r_rd;
  logic [N_NEURON*OUT_BITS-1:0]   r_m_data;
  logic                           r_cfg_err;

  logic [OUT_BITS-1:0]            r_lut  [LUT_DEPTH];
  logic [7:0]                     r_conn [CONN_DEPTH];

  logic                           w_hs_in;
  logic                           w_issue;
  logic                           w_last;
  logic                           w_cfg_ok;
  logic                           w_lut_we;
  logic                           w_conn_we;
  logic [255:0]                   w_vec_pad;
  logic [CA-1:0]                  w_conn_base;
  logic [FANIN_W-1:0]             w_pattern;
  logic [LA-1:0]                  w_lut_raddr;

  assign w_hs_in  = s_valid && (r_state == ST_IDLE);
  assign w_issue  = (r_state == ST_EVAL) && (r_n < NW'(N_NEURON));
  assign w_last   = r_v2 && (r_n2 == NW'(N_NEURON - 1));

  // Config is only legal in IDLE with no input handshake in the same cycle.
  assign w_cfg_ok  = (r_state == ST_IDLE) && !s_valid;
  assign w_lut_we  = cfg_we && w_cfg_ok && !cfg_sel && (32'(cfg_addr) < LUT_DEPTH);
  assign w_conn_we = cfg_we && w_cfg_ok &&  cfg_sel && (32'(cfg_addr) < CONN_DEPTH);

  // Zero-padding makes any connection index >= IN_W read as 0.
  assign w_vec_pad   = 256'(r_vec);
  assign w_conn_base = CA'(32'(r_n) * FANIN_W);

  always_comb begin
    w_pattern = '0;
    for (int unsigned k = 0; k < FANIN_W; k++) begin
      w_pattern[k] = w_vec_pad[r_conn[w_conn_base + CA'(k)]];
    end
  end

  assign w_lut_raddr = LA'((32'(r_n) << FANIN_W) | 32'(w_pattern));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_hs_in) w_next = ST_EVAL;
      ST_EVAL: if (w_last)  w_next = ST_OUT;
      ST_OUT:  if (m_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Pipeline: issue (address register) -> synchronous LUT read -> m_data slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec     <= '0;
      r_n       <= '0;
      r_v1      <= 1'b0;
      r_n1      <= '0;
      r_addr    <= '0;
      r_v2      <= 1'b0;
      r_n2      <= '0;
      r_m_data  <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && !(w_lut_we || w_conn_we);
      if (w_hs_in) begin
        r_vec <= s_data;
        r_n   <= '0;
      end
      r_v1 <= w_issue;
      if (w_issue) begin
        r_addr <= w_lut_raddr;
        r_n1   <= r_n;
        r_n    <= r_n + NW'(1);
      end
      r_v2 <= r_v1;
      r_n2 <= r_n1;
      if (r_v2) begin
        for (int unsigned i = 0; i < N_NEURON; i++) begin
          if (r_n2 == NW'(i)) r_m_data[i*OUT_BITS +: OUT_BITS] <= r_rd;
        end
      end
    end
  end

  // Storage arrays are not reset; contents persist across rst_n.
  always_ff @(posedge clk) begin
    if (w_lut_we) r_lut[LA'(cfg_addr)] <= cfg_data[OUT_BITS-1:0];
    if (w_conn_we) r_conn[CA'(cfg_addr)] <= cfg_data;
    if (r_v1) r_rd <= r_lut[r_addr];
  end

  assign s_ready = (r_state == ST_IDLE);
  assign m_valid = (r_state == ST_OUT);
  assign busy    = (r_state != ST_IDLE);
  assign m_data  = r_m_data;
  assign cfg_err = r_cfg_err;

`ifdef LAYER_PERF_EN
  logic [31:0] r_perf_passes;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_passes <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (m_valid && m_ready && (r_perf_passes != '1)) r_perf_passes <= r_perf_passes + 32'd1;
      if (m_valid && !m_ready && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_passes = r_perf_passes;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_logicnet_layer_sched.sv
// Randomized self-checking bench for logicnet_layer_sched against an array-based
// behavioural model of the LUT/connection tables.
module tb_logicnet_layer_sched;

  localparam int unsigned IW = 64;
  localparam int unsigned N  = 16;
  localparam int unsigned FW = 7;
  localparam int unsigned OB = 2;
  localparam int unsigned NP = 1 << FW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [IW-1:0]     s_data;
  logic              m_valid;
  logic              m_ready;
  logic [N*OB-1:0]   m_data;
  logic              cfg_we;
  logic              cfg_sel;
  logic [15:0]       cfg_addr;
  logic [7:0]        cfg_data;
  logic              cfg_err;
  logic              busy;
`ifdef LAYER_PERF_EN
  logic [31:0]       perf_passes;
  logic [31:0]       perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int lut_m  [N][NP];
  int conn_m [N][FW];

  always #5 clk = ~clk;

  logicnet_layer_sched #(
    .IN_W    (IW),
    .N_NEURON(N),
    .FANIN_W (FW),
    .OUT_BITS(OB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .cfg_we  (cfg_we),
    .cfg_sel (cfg_sel),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .cfg_err (cfg_err),
    .busy    (busy)
`ifdef LAYER_PERF_EN
    ,
    .perf_passes(perf_passes),
    .perf_stall (perf_stall)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pat_of(input int unsigned n, input logic [IW-1:0] v);
    int p = 0;
    for (int unsigned k = 0; k < FW; k++) begin
      if (conn_m[n][k] < IW && v[conn_m[n][k]]) p = p | (1 << k);
    end
    return p;
  endfunction

  function automatic logic [N*OB-1:0] model_out(input logic [IW-1:0] v);
    logic [N*OB-1:0] res = '0;
    for (int unsigned n = 0; n < N; n++) begin
      res[n*OB +: OB] = OB'(lut_m[n][pat_of(n, v)]);
    end
    return res;
  endfunction

  task automatic cfg_write(input logic sel, input int unsigned addr, input int unsigned data,
                           input logic exp_err);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_addr = 16'(addr);
    cfg_data = 8'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check_eq("cfg_err_write", 64'(cfg_err), 64'(exp_err));
    if (!exp_err) begin
      if (!sel) lut_m[addr / NP][addr % NP] = int'(data & ((1 << OB) - 1));
      else      conn_m[addr / FW][addr % FW] = int'(data & 8'hFF);
    end
  endtask

  // mode 0: plain pass; 1: rejected cfg write during EVAL; 2: cfg write alongside s_valid.
  task automatic run_pass(input logic [IW-1:0] v, input int mode);
    int cyc = 0;
    int p;
    logic [N*OB-1:0] exp = model_out(v);
    check_eq("s_ready_idle", 64'(s_ready), 64'd1);
    s_valid = 1'b1;
    s_data  = v;
    if (mode == 2) begin
      p = pat_of(0, v);
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 16'(p);
      cfg_data = 8'((lut_m[0][p] + 1) & 3);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    if (mode == 2) begin
      check_eq("cfg_err_with_svalid", 64'(cfg_err), 64'd1);
      check_eq("busy_after_hs", 64'(busy), 64'd1);
      cfg_we = 1'b0;
    end
    while (!m_valid && cyc < 60) begin
      if (mode == 1 && cyc == 2) begin
        p = pat_of(N - 1, v);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 16'((N - 1) * NP + p);
        cfg_data = 8'((lut_m[N-1][p] + 1) & 3);
      end
      @(posedge clk); #1;
      cyc++;
      if (mode == 1 && cyc == 3) begin
        check_eq("cfg_err_eval", 64'(cfg_err), 64'd1);
        cfg_we = 1'b0;
      end
    end
    check_eq("latency", 64'(cyc), 64'(N + 2));
    check_eq("m_data", 64'(m_data), 64'(exp));
    check_eq("s_ready_out", 64'(s_ready), 64'd0);
  endtask

  task automatic release_out();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check_eq("m_valid_after_hs", 64'(m_valid), 64'd0);
    check_eq("busy_after_out", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [IW-1:0] v;
    logic [N*OB-1:0] exp;
    logic [OB-1:0] slot;
    int seen;
`ifdef LAYER_PERF_EN
    logic [31:0] stall0;
    logic [31:0] pass0;
`endif
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_s_ready", 64'(s_ready), 64'd1);
    check_eq("rst_m_valid", 64'(m_valid), 64'd0);
    check_eq("rst_m_data", 64'(m_data), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_cfg_err", 64'(cfg_err), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int unsigned n = 0; n < N; n++) begin
      for (int unsigned p = 0; p < NP; p++) cfg_write(1'b0, n * NP + p, (n + p) & 3, 1'b0);
      for (int unsigned k = 0; k < FW; k++) cfg_write(1'b1, n * FW + k, n + k, 1'b0);
    end
    run_pass(64'h0000_0000_0000_00FF, 0);
    release_out();

    // Backpressure
    v = {$urandom, $urandom};
    exp = model_out(v);
`ifdef LAYER_PERF_EN
    stall0 = perf_stall;
    pass0  = perf_passes;
`endif
    run_pass(v, 0);
    for (int unsigned i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("bp_m_data", 64'(m_data), 64'(exp));
      check_eq("bp_m_valid", 64'(m_valid), 64'd1);
      check_eq("bp_s_ready", 64'(s_ready), 64'd0);
    end
    release_out();
`ifdef LAYER_PERF_EN
    check_eq("perf_stall", 64'(perf_stall), 64'(stall0 + 32'd10));
    check_eq("perf_passes", 64'(perf_passes), 64'(pass0 + 32'd1));
`endif

    // Rejected config writes must leave tables intact
    v = {$urandom, $urandom};
    run_pass(v, 1);
    release_out();
    run_pass(v, 0);
    release_out();
    run_pass(v, 2);
    release_out();
    run_pass(v, 0);
    release_out();

    // Boundaries
    cfg_write(1'b1, 3 * FW, 200, 1'b0);
    for (int unsigned k = 0; k < FW; k++) cfg_write(1'b1, 5 * FW + k, k, 1'b0);
    cfg_write(1'b0, 5 * NP + NP - 1, 3, 1'b0);
    cfg_write(1'b0, N * NP - 1, 1, 1'b0);
    cfg_write(1'b0, N * NP, 2, 1'b1);
    cfg_write(1'b1, N * FW, 0, 1'b1);
    run_pass('1, 0);
    slot = m_data[5*OB +: OB];
    check_eq("slot5_pat7F", 64'(slot), 64'd3);
    release_out();

    // Reset in the middle of EVAL
    s_valid = 1'b1; s_data = {$urandom, $urandom};
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_s_ready", 64'(s_ready), 64'd1);
    check_eq("midrst_m_data", 64'(m_data), 64'd0);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int unsigned i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (m_valid) seen++;
    end
    check_eq("midrst_no_m_valid", 64'(seen), 64'd0);
    run_pass({$urandom, $urandom}, 0);
    release_out();

    // Random reconfiguration and passes
    for (int unsigned it = 0; it < 12; it++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        cfg_write(1'b1, $urandom_range(0, N * FW - 1), $urandom_range(0, 79), 1'b0);
        cfg_write(1'b0, $urandom_range(0, N * NP - 1), $urandom_range(0, 3), 1'b0);
      end
      run_pass({$urandom, $urandom}, 0);
      release_out();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
